// File: rtl/data_mem_ctrl_pkg.sv
// datamem_pkg: shared FSM state type, counter width and default datapath widths.
package datamem_pkg;
  typedef enum logic {IDLE, WAIT} dm_state_t;
  localparam int DM_CNT_W = 4;
  localparam int DM_ADDR_W = 8;
  localparam int DM_DATA_W = 8;
endpackage

// File: rtl/data_mem_ctrl_sp_ram.sv
// sp_ram: single-port synchronous RAM, read data registered on the enable edge.
module sp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (en) begin
      if (we) r_mem[addr] <= wdata;
      else rdata <= r_mem[addr];
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data-memory controller with fixed wait latency and done pulse.
module data_mem_ctrl
  import datamem_pkg::*;
#(
  parameter int ADDR_W  = DM_ADDR_W,
  parameter int DATA_W  = DM_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] datamem_out
);
  dm_state_t           r_state;
  logic [DM_CNT_W-1:0] r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_valid;
  logic                w_acc;
  logic [DATA_W-1:0]   w_rdata;
  assign w_acc = (r_state == WAIT) && (r_cnt == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (req) begin
          r_we    <= we;
          r_addr  <= addr;
          r_wdata <= wdata;
          r_cnt   <= DM_CNT_W'(LATENCY - 1);
          r_busy  <= 1'b1;
          r_state <= WAIT;
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_state <= IDLE;
        if (!r_we) r_valid <= 1'b1;
      end
    end
  // RAM read register holds the last read; r_valid masks it to zero until the first read after reset
  sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk), .en(w_acc), .we(r_we), .addr(r_addr), .wdata(r_wdata), .rdata(w_rdata)
  );
  assign busy        = r_busy;
  assign done        = r_done;
  assign datamem_out = r_valid ? w_rdata : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: table-driven vectors plus directed multi-cycle sequences.
module tb_data_mem_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic req, we, busy, done;
  logic [7:0] addr, wdata, dout;
  logic req1, we1, busy1, done1;
  logic [7:0] addr1, wdata1, dout1;
  data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .datamem_out(dout)
  );
  data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .datamem_out(dout1)
  );
  typedef struct {
    logic req, we;
    logic [7:0] addr, wdata;
    logic busy, done;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void add(input logic r, w, input logic [7:0] a, d,
                              input logic b, dn, input logic [7:0] o);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d; v.busy = b; v.done = dn; v.dout = o;
    vecs.push_back(v);
  endfunction
  // one LATENCY=2 access: accept, wait, access; ign pulses a write of 0x3C to 0x10 while busy
  function automatic void acc(input logic w, input logic [7:0] a, d, db, da, input logic ign);
    add(1'b1, w, a, d, 1'b1, 1'b0, db);
    add(ign, 1'b1, 8'h10, 8'h3C, 1'b1, 1'b0, db);
    add(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, da);
  endfunction
  initial begin
    req = 0; we = 0; addr = 0; wdata = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    acc(1'b1, 8'h10, 8'hA5, 8'h00, 8'h00, 1'b0);
    acc(1'b0, 8'h10, 8'h00, 8'h00, 8'hA5, 1'b0);
    acc(1'b1, 8'h00, 8'h11, 8'hA5, 8'hA5, 1'b0);
    acc(1'b1, 8'h01, 8'h22, 8'hA5, 8'hA5, 1'b0);
    acc(1'b1, 8'h02, 8'h33, 8'hA5, 8'hA5, 1'b0);
    acc(1'b1, 8'h03, 8'h44, 8'hA5, 8'hA5, 1'b0);
    acc(1'b0, 8'h00, 8'h00, 8'hA5, 8'h11, 1'b1);
    acc(1'b0, 8'h10, 8'h00, 8'h11, 8'hA5, 1'b0);
    acc(1'b1, 8'h20, 8'h07, 8'hA5, 8'hA5, 1'b0);
    add(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5);
    #3 rst = 1'b1;
    #1;
    chk("rst busy", 8'(busy), 8'h0);
    chk("rst done", 8'(done), 8'h0);
    chk("rst dout", dout, 8'h00);
    chk("rst busy1", 8'(busy1), 8'h0);
    chk("rst dout1", dout1, 8'h00);
    #3 rst = 1'b0;
    step();
    foreach (vecs[i]) begin
      req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      step();
      chk($sformatf("vec%0d busy", i), 8'(busy), 8'(vecs[i].busy));
      chk($sformatf("vec%0d done", i), 8'(done), 8'(vecs[i].done));
      chk($sformatf("vec%0d dout", i), dout, vecs[i].dout);
    end
    req = 1'b1; we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr = 8'(k);
      step();
      chk($sformatf("b2b%0d accept busy", k), 8'(busy), 8'h1);
      chk($sformatf("b2b%0d accept done", k), 8'(done), 8'h0);
      step();
      chk($sformatf("b2b%0d wait busy", k), 8'(busy), 8'h1);
      step();
      chk($sformatf("b2b%0d done", k), 8'(done), 8'h1);
      chk($sformatf("b2b%0d dout", k), dout, 8'(8'h11 * (k + 1)));
    end
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'hFF;
    step();
    chk("abort accept busy", 8'(busy), 8'h1);
    req = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 8'(busy), 8'h0);
    chk("abort done", 8'(done), 8'h0);
    chk("abort dout", dout, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("abort no done %0d", k), 8'(done), 8'h0);
    end
    req = 1'b1; we = 1'b0; addr = 8'h20;
    step();
    req = 1'b0;
    step();
    step();
    chk("abort read done", 8'(done), 8'h1);
    chk("abort read dout", dout, 8'h07);
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'h5A;
    step();
    chk("l1 wr busy", 8'(busy1), 8'h1);
    req1 = 1'b0;
    step();
    chk("l1 wr done", 8'(done1), 8'h1);
    chk("l1 wr dout", dout1, 8'h00);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    step();
    chk("l1 rd busy", 8'(busy1), 8'h1);
    chk("l1 rd done0", 8'(done1), 8'h0);
    addr1 = 8'h11;
    step();
    chk("l1 rd done", 8'(done1), 8'h1);
    chk("l1 rd notbusy", 8'(busy1), 8'h0);
    chk("l1 rd dout", dout1, 8'h5A);
    step();
    chk("l1 reaccept busy", 8'(busy1), 8'h1);
    chk("l1 reaccept done", 8'(done1), 8'h0);
    req1 = 1'b0;
    step();
    chk("l1 second done", 8'(done1), 8'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

- Multi-cycle controller and storage for the 8-bit datapath's data memory.
- Accepts one read or write request at a time, inserts a fixed number of wait cycles, then performs the access.
- Presents read data on `datamem_out`, the memory-side input of the bus-D write-back multiplexer, and holds it stable until the next read completes.
- Signals completion with a one-cycle `done` pulse, which the control unit uses to advance past memory instructions.

## Interface

**Parameters**
- `ADDR_W`, default 8: address width; the array holds 2^ADDR_W words.
- `DATA_W`, default 8: word width; must match the bus-D width.
- `LATENCY`, default 2: clock edges from accept to access. Legal range 1..15.

**Ports**
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  1: access request, sampled only in IDLE.
- `we`  in  1: 1 = write, 0 = read; sampled together with `req`.
- `addr`  in  ADDR_W: word address; sampled with `req`.
- `wdata`  in  DATA_W: write data from bus B; sampled with `req`.
- `busy`  out  1: high while an accepted access is pending.
- `done`  out  1: one-cycle pulse after the access is performed, for both reads and writes.
- `datamem_out`  out  DATA_W: last completed read data, registered.

## Operation

**States:** IDLE, WAIT.

**IDLE**
- On a rising edge with `req`=1, latch `we`, `addr` and `wdata`.
- Load the wait counter with LATENCY-1, set `busy`=1, go to WAIT.
- `req`=0: remain in IDLE.

**WAIT**
- If counter ≠ 0: decrement.
- If counter = 0 (the LATENCY-th edge after accept), perform the access on this edge:
  - write: `mem[addr_q] <= wdata_q`; `datamem_out` unchanged.
  - read: `datamem_out <= mem[addr_q]`.
- Also on that edge: `busy` <= 0, `done` <= 1, go to IDLE.

**done**
- Registered.
- High for exactly the one cycle following the access edge; cleared on the next edge.

**Request rules**
- `req` while `busy`=1 is ignored, not queued. The requester must hold or re-assert it.
- The `done` cycle is an IDLE cycle: a `req` present then is accepted at the following edge.
- Port changes after accept have no effect on the pending access.

**Reset**
- Asynchronous; forces IDLE, `busy`=0, `done`=0, `datamem_out`=0, counter=0.
- Reset mid-WAIT aborts the access: a pending write is not committed.
- The memory array is not reset; contents persist across `rst`.

**Addressing**
- Full address space is valid.
- No out-of-range condition; no wrap logic needed.

## Timing

- Accept edge E0 (IDLE, `req`=1): `busy`=1 from just after E0.
- Access edge E_LATENCY:
  - `datamem_out` valid just after E_LATENCY (reads).
  - `busy`=0 and `done`=1 for the cycle [E_LATENCY, E_LATENCY+1).
- Read latency: LATENCY cycles from the accept edge to valid data.
- Maximum throughput: one access per LATENCY+1 cycles.
- LATENCY=1: access on E1; WAIT lasts one cycle.
- `datamem_out` is stable in all cycles except immediately after a read access edge. The downstream mux therefore sees a glitch-free registered source.

## Structure

- Shared package `datamem_pkg`:
  - state enum `dm_state_t` {IDLE, WAIT}.
  - `DM_CNT_W` = 4, the counter width.
  - default `ADDR_W`/`DATA_W` constants shared with the datapath.
- Sub-module `sp_ram`:
  - single-port synchronous RAM, parameterised by ADDR_W/DATA_W.
  - ports: `clk`, `en`, `we`, `addr`, `wdata`, `rdata`.
  - no reset; read data registered on the enable edge.
- The controller FSM, counter, request latches and `done` live in `data_mem_ctrl`.

## Test plan

- **Reset values:** `rst` pulse mid-cycle, asynchronous to `clk` → `busy`=0, `done`=0, `datamem_out`=0x00 immediately, without waiting for an edge.
- **Write then read, LATENCY=2:**
  - write 0xA5 to 0x10 → `done` pulses 2 cycles after accept; `datamem_out` stays 0x00.
  - read 0x10 → `datamem_out`=0xA5 exactly 2 cycles after accept, coincident with the start of the `done` pulse.
- **Ignored request:** during `busy`, pulse `req` with write 0x3C to 0x10 → no effect. A subsequent read of 0x10 returns 0xA5.
- **Back-to-back:** hold `req`=1 with reads of 0x00..0x03, preloaded with 0x11, 0x22, 0x33, 0x44 → accepts spaced LATENCY+1 cycles apart; `datamem_out` steps 0x11→0x22→0x33→0x44; four `done` pulses.
- **Reset mid-operation:** write 0xFF to 0x20 (preloaded 0x07), assert `rst` one cycle after accept → no `done`. Read of 0x20 after reset returns 0x07.
- **LATENCY=1 build:** read 0x10 holding 0x5A → `datamem_out`=0x5A and `done`=1 in the cycle after E1; a new `req` is accepted at E2.
